// File: rtl/aes_core_arbiter.sv
// Two-requester front end for one AES-128 core; optional wait timeout under AES_ARB_TIMEOUT_EN.
// Latency: accept->core_start 1 cycle, core_valid->rsp_valid 1 cycle.
// Backpressure: one block in flight; req_ready stays low until the held response is taken.
module aes_core_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [127:0] req_key0,
  input  logic [127:0] req_key1,
  input  logic [127:0] req_pt0,
  input  logic [127:0] req_pt1,
  output logic [1:0]   rsp_valid,
  input  logic [1:0]   rsp_ready,
  output logic [127:0] rsp_data,
  output logic         rsp_err,
  output logic         core_start,
  output logic [127:0] core_key,
  output logic [127:0] core_plaintext,
  input  logic [127:0] core_ciphertext,
  input  logic         core_valid,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t state, state_nxt;
  logic   ptr;
  logic   gnt;
  logic   gnt_q;
  logic   accept;
  logic   core_done;
  logic   rsp_done;
  logic   timeout;

  if (TIMEOUT_CYCLES < 16 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("aes_core_arbiter: TIMEOUT_CYCLES must be within 16..255");
  end

  // A lone requester wins outright; contention is settled by the alternating pointer.
  always_comb begin
    gnt = ptr;
    case (req_valid)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
      default: gnt = ptr;
    endcase
  end

  assign accept     = (state == IDLE) && (req_valid != 2'b00);
  assign req_ready  = accept ? (gnt ? 2'b10 : 2'b01) : 2'b00;
  assign core_done  = (state == WAIT) && core_valid;
  assign rsp_done   = (state == RESP) && rsp_ready[gnt_q];
  assign core_start = (state == ISSUE);
  assign busy       = (state != IDLE);
  assign rsp_valid  = (state == RESP) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;

`ifdef AES_ARB_TIMEOUT_EN
  logic [7:0] timer;
  logic [7:0] timer_inc;
  logic       rsp_err_q;

  assign timer_inc = timer + 8'd1;
  assign timeout   = (state == WAIT) && !core_valid && (timer_inc == 8'(TIMEOUT_CYCLES));
  assign rsp_err   = rsp_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      timer     <= 8'd0;
      rsp_err_q <= 1'b0;
    end else begin
      if (state == ISSUE) begin
        timer <= 8'd0;
      end else if (state == WAIT) begin
        timer <= timer_inc;
      end
      if (core_done) begin
        rsp_err_q <= 1'b0;
      end else if (timeout) begin
        rsp_err_q <= 1'b1;
      end
    end
  end
`else
  assign timeout = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT:  if (core_done || timeout) state_nxt = RESP;
      RESP:  if (rsp_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are only written on accept, so they hold steady for the core until the next grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr            <= 1'b0;
      gnt_q          <= 1'b0;
      core_key       <= '0;
      core_plaintext <= '0;
      rsp_data       <= '0;
    end else begin
      if (accept) begin
        core_key       <= gnt ? req_key1 : req_key0;
        core_plaintext <= gnt ? req_pt1 : req_pt0;
        ptr            <= ~gnt;
        gnt_q          <= gnt;
      end
      if (core_done) begin
        rsp_data <= core_ciphertext;
      end else if (timeout) begin
        rsp_data <= '0;
      end
    end
  end

endmodule
